// File: rtl/win_checker_if.sv
// rtl/win_checker_if.sv - board/result bundle between game logic and the win checker
interface win_checker_if #(
  parameter int ROWS   = 6,
  parameter int COLS   = 7,
  parameter int CELL_W = 3
);
  logic                                    start;
  logic                                    new_game;
  logic [CELL_W-1:0][ROWS-1:0][COLS-1:0]   board;
  logic                                    busy;
  logic                                    done;
  logic                                    juego_terminado;
  logic [1:0]                              winner;
  logic                                    draw;
  logic [2:0]                              win_row;
  logic [2:0]                              win_col;
  logic [1:0]                              win_dir;

  modport master (
    output start, new_game, board,
    input  busy, done, juego_terminado, winner, draw, win_row, win_col, win_dir
  );

  modport slave (
    input  start, new_game, board,
    output busy, done, juego_terminado, winner, draw, win_row, win_col, win_dir
  );
endinterface

// File: rtl/win_checker.sv
// rtl/win_checker.sv - sequential Connect-4 win/draw scanner, one anchor/direction per cycle
// WIN_CHECKER_DIAG_EN adds the two diagonal directions (NDIR 4 instead of 2).
module win_checker #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int CELL_W  = 3,
  parameter int RUN_LEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  win_checker_if.slave   bus
);

`ifdef WIN_CHECKER_DIAG_EN
  localparam int NDIR = 4;
`else
  localparam int NDIR = 2;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t                                state_q, state_d;
  logic [CELL_W-1:0][ROWS-1:0][COLS-1:0] snap_q, snap_d;
  logic [2:0]                            r_q, r_d, c_q, c_d;
  logic [1:0]                            d_q, d_d;
  logic                                  jt_q, jt_d, draw_q, draw_d;
  logic [1:0]                            winner_q, winner_d, dir_q, dir_d;
  logic [2:0]                            row_q, row_d, col_q, col_d;

  logic [1:0]        norm [ROWS][COLS];
  logic [CELL_W-1:0] cell_v;
  logic              board_full;
  logic [1:0]        anchor;
  logic              hit, match, last_idx;
  int                dr, dc, tr, tc;

  // Codes other than 1/2 collapse to empty so the run compare only sees real pieces.
  always_comb begin
    board_full = 1'b1;
    cell_v     = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cell_v = '0;
        for (int b = 0; b < CELL_W; b++) cell_v[b] = snap_q[b][r][c];
        norm[r][c] = (cell_v == CELL_W'(1)) ? 2'd1 :
                     (cell_v == CELL_W'(2)) ? 2'd2 : 2'd0;
        if (norm[r][c] == 2'd0) board_full = 1'b0;
      end
    end
  end

  always_comb begin
    case (d_q)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    anchor = 2'd0;
    hit    = 1'b1;
    match  = 1'b0;
    tr     = 0;
    tc     = 0;
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++)
        if (rr == int'(r_q) && cc == int'(c_q)) anchor = norm[rr][cc];
    if (anchor == 2'd0) hit = 1'b0;
    // Out-of-bounds candidates are a miss; never wrap to the next row.
    for (int i = 1; i < RUN_LEN; i++) begin
      tr = int'(r_q) + i * dr;
      tc = int'(c_q) + i * dc;
      if (tr < 0 || tr >= ROWS || tc < 0 || tc >= COLS) begin
        hit = 1'b0;
      end else begin
        match = 1'b0;
        for (int rr = 0; rr < ROWS; rr++)
          for (int cc = 0; cc < COLS; cc++)
            if (rr == tr && cc == tc && norm[rr][cc] == anchor) match = 1'b1;
        if (!match) hit = 1'b0;
      end
    end
  end

  assign last_idx = (r_q == 3'(ROWS - 1)) && (c_q == 3'(COLS - 1)) && (d_q == 2'(NDIR - 1));

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    r_d      = r_q;
    c_d      = c_q;
    d_d      = d_q;
    jt_d     = jt_q;
    draw_d   = draw_q;
    winner_d = winner_q;
    row_d    = row_q;
    col_d    = col_q;
    dir_d    = dir_q;
    case (state_q)
      IDLE: if (bus.start && !jt_q) state_d = LOAD;
      LOAD: begin
        snap_d  = bus.board;
        r_d     = '0;
        c_d     = '0;
        d_d     = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (hit) begin
          winner_d = anchor;
          row_d    = r_q;
          col_d    = c_q;
          dir_d    = d_q;
          jt_d     = 1'b1;
          state_d  = DONE;
        end else if (last_idx) begin
          if (board_full) begin
            draw_d = 1'b1;
            jt_d   = 1'b1;
          end
          state_d = DONE;
        end else if (d_q == 2'(NDIR - 1)) begin
          d_d = '0;
          if (c_q == 3'(COLS - 1)) begin
            c_d = '0;
            r_d = r_q + 3'd1;
          end else begin
            c_d = c_q + 3'd1;
          end
        end else begin
          d_d = d_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.new_game) begin
      state_d  = IDLE;
      jt_d     = 1'b0;
      draw_d   = 1'b0;
      winner_d = 2'd0;
      row_d    = '0;
      col_d    = '0;
      dir_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      r_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      jt_q     <= 1'b0;
      draw_q   <= 1'b0;
      winner_q <= 2'd0;
      row_q    <= '0;
      col_q    <= '0;
      dir_q    <= '0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      r_q      <= r_d;
      c_q      <= c_d;
      d_q      <= d_d;
      jt_q     <= jt_d;
      draw_q   <= draw_d;
      winner_q <= winner_d;
      row_q    <= row_d;
      col_q    <= col_d;
      dir_q    <= dir_d;
    end
  end

  assign bus.busy            = (state_q == LOAD) || (state_q == SCAN);
  assign bus.done            = (state_q == DONE);
  assign bus.juego_terminado = jt_q;
  assign bus.winner          = winner_q;
  assign bus.draw            = draw_q;
  assign bus.win_row         = row_q;
  assign bus.win_col         = col_q;
  assign bus.win_dir         = dir_q;

endmodule

// File: tb/tb_win_checker.sv
// tb/tb_win_checker.sv - scoreboard bench for win_checker with directed boards
module tb_win_checker;

  typedef struct {
    int t;
    int lat;
    int busy_n;
    int winner;
    int jt;
    int draw;
    int row;
    int col;
    int dir;
  } exp_t;

`ifdef WIN_CHECKER_DIAG_EN
  localparam int NOHIT_LAT  = 170;
  localparam int K_DIAG     = 71;
  localparam int K_VERT     = 81;
  localparam int K_ROW5     = 152;
`else
  localparam int NOHIT_LAT  = 86;
  localparam int K_VERT     = 41;
  localparam int K_ROW5     = 76;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   bcnt = 0;
  exp_t sb[$];

  win_checker_if bus ();

  win_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks each done pulse against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      bcnt = 0;
    end else begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done cycle=%0d expected no done", cyc + 1);
        end else begin
          e = sb.pop_front();
          check("done_latency", cyc + 1 - e.t, e.lat);
          check("busy_cycles", bcnt, e.busy_n);
          check("winner", int'(bus.winner), e.winner);
          check("juego_terminado", int'(bus.juego_terminado), e.jt);
          check("draw", int'(bus.draw), e.draw);
          check("win_row", int'(bus.win_row), e.row);
          check("win_col", int'(bus.win_col), e.col);
          check("win_dir", int'(bus.win_dir), e.dir);
        end
        bcnt = 0;
      end
    end
  end

  task automatic set_cell(input int r, input int c, input int v);
    for (int b = 0; b < 3; b++) bus.board[b][r][c] = v[b];
  endtask

  task automatic issue(input int lat, input int winner, input int jt, input int draw,
                       input int row, input int col, input int dir);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    e.t = cyc + 1;
    e.lat = lat;
    e.busy_n = lat - 1;
    e.winner = winner;
    e.jt = jt;
    e.draw = draw;
    e.row = row;
    e.col = col;
    e.dir = dir;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout_done pending=%0d expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_game();
    @(negedge clk);
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    check("ng_winner", int'(bus.winner), 0);
    check("ng_juego_terminado", int'(bus.juego_terminado), 0);
    check("ng_draw", int'(bus.draw), 0);
    bus.board = '0;
  endtask

  initial begin
    int t0;
    bus.start = 1'b0;
    bus.new_game = 1'b0;
    bus.board = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_jt", int'(bus.juego_terminado), 0);
    check("rst_winner", int'(bus.winner), 0);
    rst = 1'b1;
    @(negedge clk);

    // Empty board: full-length scan, no result.
    issue(NOHIT_LAT, 0, 0, 0, 0, 0, 0);
    drain();

    // Player 1 horizontal at row 0 cols 0..3: first step hits.
    for (int c = 0; c < 4; c++) set_cell(0, c, 1);
    issue(3, 1, 1, 0, 0, 0, 0);
    drain();
    clear_game();

    // Player 2 anti-diagonal anchored at (2,3).
    set_cell(2, 3, 2); set_cell(3, 2, 2); set_cell(4, 1, 2); set_cell(5, 0, 2);
`ifdef WIN_CHECKER_DIAG_EN
    issue(K_DIAG + 3, 2, 1, 0, 2, 3, 3);
`else
    issue(NOHIT_LAT, 0, 0, 0, 0, 0, 0);
`endif
    drain();
    clear_game();

    // Player 2 vertical on the last column, rows 2..5.
    for (int r = 2; r < 6; r++) set_cell(r, 6, 2);
    issue(K_VERT + 3, 2, 1, 0, 2, 6, 1);
    drain();
    clear_game();

    // Player 1 horizontal touching the right edge of the bottom row.
    for (int c = 3; c < 7; c++) set_cell(5, c, 1);
    issue(K_ROW5 + 3, 1, 1, 0, 5, 3, 0);
    drain();
    clear_game();

    // Row-wrap bait and codes >2 must not count as a run.
    set_cell(0, 5, 1); set_cell(0, 6, 1); set_cell(1, 0, 1); set_cell(1, 1, 1);
    for (int c = 0; c < 4; c++) set_cell(3, c, 3);
    issue(NOHIT_LAT, 0, 0, 0, 0, 0, 0);
    drain();
    clear_game();

    // Full board with runs of at most two in every direction: draw.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        set_cell(r, c, 1 + (((c >> 1) + r) & 1));
    issue(NOHIT_LAT, 0, 1, 1, 0, 0, 0);
    drain();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("over_start_ignored_busy", int'(bus.busy), 0);
      @(negedge clk);
    end
    clear_game();

    // Start held two cycles plus a retrigger mid-scan: one done only.
    issue(NOHIT_LAT, 0, 0, 0, 0, 0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (NOHIT_LAT) @(negedge clk);

    // Asynchronous reset at T+50 aborts the scan.
    @(negedge clk);
    bus.start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc + 1 < t0 + 50) @(negedge clk);
    check("pre_rst_busy", int'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_done", int'(bus.done), 0);
    check("async_rst_jt", int'(bus.juego_terminado), 0);
    check("async_rst_row", int'(bus.win_row), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle_busy", int'(bus.busy), 0);
    repeat (NOHIT_LAT) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
